// File: rtl/xbar_l2_pkg.sv
// -----------------------------------------------------------------------------
// xbar_l2_pkg
// Shared parameters of the L2 crossbar: channel count, data width, response
// tracking depth, and helpers that derive the channel-ID, FIFO pointer and
// outstanding-count widths from them.
// -----------------------------------------------------------------------------
package xbar_l2_pkg;

    // Crossbar-wide defaults
    localparam int unsigned XBAR_L2_N_CH       = 4;
    localparam int unsigned XBAR_L2_DATA_WIDTH = 32;

    // Maximum accepted requests awaiting a response (power of two, >= 2)
    localparam int unsigned XBAR_L2_DEPTH      = 4;

    // Width of a channel index
    function automatic int unsigned id_width_f(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // FIFO pointer width; the pointers wrap naturally modulo depth
    function automatic int unsigned ptr_width_f(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy width; one extra bit so that the value depth itself fits
    function automatic int unsigned cnt_width_f(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : xbar_l2_pkg

// File: rtl/xbar_l2_id_fifo.sv
// -----------------------------------------------------------------------------
// xbar_l2_id_fifo
// In-order FIFO of channel IDs for requests the bank has accepted but not yet
// answered. Storage carries no reset; only pointers and occupancy do.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : write id_i at the next edge (ignored while full)
//   pop_i       : drop the head entry at the next edge (ignored while empty)
//   id_i        : ID to store
//   full_o      : occupancy equals DEPTH
//   empty_o     : occupancy is zero
//   count_o     : current occupancy, 0..DEPTH
//   head_o      : oldest stored ID (only meaningful while not empty)
// -----------------------------------------------------------------------------
module xbar_l2_id_fifo
    import xbar_l2_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 2,
    parameter int unsigned DEPTH    = XBAR_L2_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [ID_WIDTH-1:0]           id_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [cnt_width_f(DEPTH)-1:0] count_o,
    output logic [ID_WIDTH-1:0]           head_o
);

    localparam int unsigned PTR_W = ptr_width_f(DEPTH);
    localparam int unsigned CNT_W = cnt_width_f(DEPTH);

    logic [ID_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push_s, pop_s, full_s, empty_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});
    // Guard locally as well so the FIFO can never over- or underflow
    assign push_s  = push_i & ~full_s;
    assign pop_s   = pop_i & ~empty_s;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Simultaneous push and pop leaves the occupancy unchanged
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID storage, written on push only
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= id_i;
        end
    end

    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule : xbar_l2_id_fifo

// File: rtl/xbar_l2_rsp_route.sv
// -----------------------------------------------------------------------------
// xbar_l2_rsp_route
// Routes L2 bank responses back to the initiator channel that issued each
// request. IDs of accepted requests are queued in order; every bank response
// is steered to the channel at the head of the queue with no added latency.
// New requests are blocked while the queue is full.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   data_req_i      : arbitrated request toward the bank
//   data_ID_i       : channel index that won arbitration
//   data_req_o      : request forwarded to the bank (masked while full)
//   data_gnt_i      : bank grant
//   data_gnt_o      : grant returned to the arbiter (masked while full)
//   data_r_valid_i  : bank response valid
//   data_r_rdata_i  : bank read data
//   data_r_valid_o  : one-hot per-channel response valid
//   data_r_rdata_o  : read data broadcast to all channels
//   outstanding_o   : accepted requests still awaiting a response
//   rsp_err_o       : one-cycle pulse after a response arrived with nothing
//                     outstanding
// -----------------------------------------------------------------------------
module xbar_l2_rsp_route
    import xbar_l2_pkg::*;
#(
    parameter int unsigned N_CH       = XBAR_L2_N_CH,
    parameter int unsigned ID_WIDTH   = id_width_f(N_CH),
    parameter int unsigned DATA_WIDTH = XBAR_L2_DATA_WIDTH,
    parameter int unsigned DEPTH      = XBAR_L2_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          data_req_i,
    input  logic [ID_WIDTH-1:0]           data_ID_i,
    output logic                          data_req_o,
    input  logic                          data_gnt_i,
    output logic                          data_gnt_o,
    input  logic                          data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]         data_r_rdata_i,
    output logic [N_CH-1:0]               data_r_valid_o,
    output logic [DATA_WIDTH-1:0]         data_r_rdata_o,
    output logic [cnt_width_f(DEPTH)-1:0] outstanding_o,
    output logic                          rsp_err_o
);

    localparam int unsigned CNT_W = cnt_width_f(DEPTH);

    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic [ID_WIDTH-1:0] head_s;
    logic [CNT_W-1:0]    count_s;
    logic [N_CH-1:0]     r_valid_s;
    logic                rsp_err_q, rsp_err_d;

    // Handshake masking keeps the bank from accepting what cannot be tracked
    assign data_req_o = data_req_i & ~full_s;
    assign data_gnt_o = data_gnt_i & ~full_s;

    // An accept is a forwarded request the bank grants
    assign push_s = data_req_o & data_gnt_i;
    // A response consumes the head only if something is outstanding; a
    // same-cycle push is not yet visible and cannot satisfy it
    assign pop_s  = data_r_valid_i & ~empty_s;

    xbar_l2_id_fifo #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .id_i    (data_ID_i),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s),
        .head_o  (head_s)
    );

    // One-hot decode of the head ID; IDs beyond N_CH match no channel
    always_comb begin
        r_valid_s = {N_CH{1'b0}};
        if (pop_s) begin
            for (int c = 0; c < N_CH; c++) begin
                r_valid_s[c] = (head_s == ID_WIDTH'(c));
            end
        end else begin
            r_valid_s = {N_CH{1'b0}};
        end
    end

    // Error flag next-state: response with no request outstanding
    always_comb begin
        rsp_err_d = 1'b0;
        if (data_r_valid_i && empty_s) begin
            rsp_err_d = 1'b1;
        end else begin
            rsp_err_d = 1'b0;
        end
    end

    // Registered error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign data_r_valid_o = r_valid_s;
    assign data_r_rdata_o = data_r_rdata_i;
    assign outstanding_o  = count_s;
    assign rsp_err_o      = rsp_err_q;

endmodule : xbar_l2_rsp_route

// File: tb/tb_xbar_l2_rsp_route.sv
// -----------------------------------------------------------------------------
// tb_xbar_l2_rsp_route
// Self-checking bench: a queue-based model of the outstanding IDs predicts
// every output each cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_xbar_l2_rsp_route;

    localparam int N_CH  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic [1:0]  id_i = 2'd0;
    logic        gnt_i = 1'b0;
    logic        rv_i = 1'b0;
    logic [31:0] rdata_i = 32'd0;

    logic        req_o;
    logic        gnt_o;
    logic [3:0]  rv_o;
    logic [31:0] rdata_o;
    logic [2:0]  outst_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: outstanding IDs in acceptance order, and the error pulse
    int q[$];
    bit err_m = 1'b0;

    xbar_l2_rsp_route dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (req_i),
        .data_ID_i      (id_i),
        .data_req_o     (req_o),
        .data_gnt_i     (gnt_i),
        .data_gnt_o     (gnt_o),
        .data_r_valid_i (rv_i),
        .data_r_rdata_i (rdata_i),
        .data_r_valid_o (rv_o),
        .data_r_rdata_o (rdata_o),
        .outstanding_o  (outst_o),
        .rsp_err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update at each clock edge (and on reset assertion)
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                err_m = 1'b0;
            end else begin
                bit was_full;
                bit was_empty;
                was_full  = (q.size() == DEPTH);
                was_empty = (q.size() == 0);
                err_m = rv_i && was_empty;
                if (rv_i && !was_empty) begin
                    void'(q.pop_front());
                end
                if (req_i && gnt_i && !was_full) begin
                    q.push_back(int'(id_i));
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial begin
        forever begin
            logic [3:0] exp_v;
            bit         full_m;
            @(negedge clk);
            full_m = (q.size() == DEPTH);
            exp_v  = 4'b0000;
            if (rv_i && q.size() > 0 && q[0] < N_CH) begin
                exp_v[q[0]] = 1'b1;
            end
            chk("sb_req_o",   {63'd0, req_o}, {63'd0, (req_i && !full_m)});
            chk("sb_gnt_o",   {63'd0, gnt_o}, {63'd0, (gnt_i && !full_m)});
            chk("sb_valid_o", {60'd0, rv_o},  {60'd0, exp_v});
            chk("sb_rdata_o", {32'd0, rdata_o}, {32'd0, rdata_i});
            chk("sb_outst_o", {61'd0, outst_o}, 64'(q.size()));
            chk("sb_err_o",   {63'd0, err_o}, {63'd0, err_m});
        end
    end

    // Apply one cycle of inputs shortly after the edge, return at mid-cycle
    task automatic step(input bit rq, input logic [1:0] id, input bit gn, input bit rv);
        @(posedge clk);
        #1;
        req_i   = rq;
        id_i    = id;
        gnt_i   = gn;
        rv_i    = rv;
        rdata_i = $urandom();
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        gnt_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outst", {61'd0, outst_o}, 64'd0);
        chk("rst_err",   {63'd0, err_o},   64'd0);
        chk("rst_gnt",   {63'd0, gnt_o},   64'd1);
        #1 rst_n = 1'b1;

        // Accepts 2,0,3 then three responses in order
        step(1'b1, 2'd2, 1'b1, 1'b0);
        step(1'b1, 2'd0, 1'b1, 1'b0);
        step(1'b1, 2'd3, 1'b1, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("ord_outst3", {61'd0, outst_o}, 64'd3);
        chk("ord_v0", {60'd0, rv_o}, 64'b0100);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("ord_v1", {60'd0, rv_o}, 64'b0001);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("ord_v2", {60'd0, rv_o}, 64'b1000);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        chk("ord_drained", {61'd0, outst_o}, 64'd0);

        // Fill to DEPTH, then a blocked request
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b1, 1'b0);
        step(1'b1, 2'd1, 1'b1, 1'b0);
        chk("full_outst", {61'd0, outst_o}, 64'd4);
        chk("full_gnt_o", {63'd0, gnt_o},   64'd0);
        chk("full_req_o", {63'd0, req_o},   64'd0);

        // Full with response and request together: pop only, accept next cycle
        step(1'b1, 2'd1, 1'b1, 1'b1);
        chk("fullpop_v",   {60'd0, rv_o},  64'b0001);
        chk("fullpop_req", {63'd0, req_o}, 64'd0);
        step(1'b1, 2'd1, 1'b1, 1'b0);
        chk("freed_outst", {61'd0, outst_o}, 64'd3);
        chk("freed_req",   {63'd0, req_o},   64'd1);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        chk("refill_outst", {61'd0, outst_o}, 64'd4);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("dr_v0", {60'd0, rv_o}, 64'b0010);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("dr_v1", {60'd0, rv_o}, 64'b0100);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("dr_v2", {60'd0, rv_o}, 64'b1000);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("dr_v3", {60'd0, rv_o}, 64'b0010);

        // Simultaneous push and pop at outstanding=2
        step(1'b1, 2'd3, 1'b1, 1'b0);
        step(1'b1, 2'd0, 1'b1, 1'b0);
        step(1'b1, 2'd1, 1'b1, 1'b1);
        chk("pp_v0",    {60'd0, rv_o},    64'b1000);
        chk("pp_outst", {61'd0, outst_o}, 64'd2);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("pp_hold",  {61'd0, outst_o}, 64'd2);
        chk("pp_v1",    {60'd0, rv_o},    64'b0001);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("pp_v2",    {60'd0, rv_o},    64'b0010);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        chk("pp_empty", {61'd0, outst_o}, 64'd0);

        // Response while empty
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("emp_v",   {60'd0, rv_o},    64'd0);
        chk("emp_err0", {63'd0, err_o},  64'd0);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        chk("emp_err1",  {63'd0, err_o},   64'd1);
        chk("emp_outst", {61'd0, outst_o}, 64'd0);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        chk("emp_err2", {63'd0, err_o}, 64'd0);

        // Response while empty with a same-cycle push
        step(1'b1, 2'd2, 1'b1, 1'b1);
        chk("ep_v", {60'd0, rv_o}, 64'd0);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        chk("ep_err",   {63'd0, err_o},   64'd1);
        chk("ep_outst", {61'd0, outst_o}, 64'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("ep_v2", {60'd0, rv_o}, 64'b0100);
        step(1'b0, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset with three outstanding
        step(1'b1, 2'd1, 1'b1, 1'b0);
        step(1'b1, 2'd2, 1'b1, 1'b0);
        step(1'b1, 2'd3, 1'b1, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        chk("ar_outst3", {61'd0, outst_o}, 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_async", {61'd0, outst_o}, 64'd0);
        #1 rst_n = 1'b1;
        step(1'b0, 2'd0, 1'b1, 1'b0);
        chk("ar_gnt", {63'd0, gnt_o}, 64'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("ar_v", {60'd0, rv_o}, 64'd0);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        chk("ar_err", {63'd0, err_o}, 64'd1);

        // Randomized traffic, with one mid-run asynchronous reset
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4));
            if (i == 1000) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        step(1'b0, 2'd0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_xbar_l2_rsp_route

// File: doc/xbar_l2_rsp_route.md
XBAR_L2_RSP_ROUTE -- requirements
Module: xbar_l2_rsp_route

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of initiator channels sharing one L2 bank port.
REQ-002 The block SHALL have parameter ID_WIDTH, default $clog2(N_CH): width of the channel index.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32: read-data width.
REQ-004 The block SHALL have parameter DEPTH, default 4 (power of two, >=2): maximum outstanding accepted requests.
REQ-005 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 The block SHALL have port data_req_i, input, 1: arbitrated request toward the bank.
REQ-008 The block SHALL have port data_ID_i, input, ID_WIDTH: index of the channel that won arbitration.
REQ-009 The block SHALL have port data_req_o, input-qualified output, 1: request forwarded to the bank.
REQ-010 The block SHALL have port data_gnt_i, input, 1: bank grant.
REQ-011 The block SHALL have port data_gnt_o, output, 1: grant returned to the arbiter and its round-robin flag.
REQ-012 The block SHALL have port data_r_valid_i, input, 1: bank response valid.
REQ-013 The block SHALL have port data_r_rdata_i, input, DATA_WIDTH: bank read data.
REQ-014 The block SHALL have port data_r_valid_o, output, N_CH: one-hot per-channel response valid.
REQ-015 The block SHALL have port data_r_rdata_o, output, DATA_WIDTH: read data broadcast to all channels.
REQ-016 The block SHALL have port outstanding_o, output, $clog2(DEPTH)+1: count of accepted requests awaiting a response.
REQ-017 The block SHALL have port rsp_err_o, output, 1: one-cycle pulse flagging a response received with nothing outstanding.

Function
REQ-018 The block SHALL drive data_req_o = data_req_i & ~full and data_gnt_o = data_gnt_i & ~full, combinationally.
REQ-019 An accept SHALL be defined as data_req_o & data_gnt_i; on each accept the block SHALL push data_ID_i into an in-order ID FIFO at the next rising edge.
REQ-020 On data_r_valid_i with the FIFO non-empty, the block SHALL assert data_r_valid_o[head ID] in the same cycle with zero added latency, and pop the head at the next edge.
REQ-021 data_r_valid_o SHALL be all-zero whenever data_r_valid_i is low or the FIFO is empty.
REQ-022 data_r_rdata_o SHALL equal data_r_rdata_i unconditionally.
REQ-023 full SHALL be asserted when outstanding equals DEPTH; while full, no push SHALL occur, and a same-cycle pop SHALL free one slot for the following cycle only.
REQ-024 A simultaneous push and pop with 0 < outstanding < DEPTH SHALL leave outstanding unchanged and preserve FIFO order.
REQ-025 data_r_valid_i while empty SHALL pulse rsp_err_o for one cycle, pop nothing, and leave any same-cycle push unaffected; a same-cycle push SHALL NOT satisfy that response.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; outstanding SHALL saturate in neither direction beyond 0..DEPTH.
REQ-027 data_ID_i values >= N_CH SHALL be stored as given, and their response SHALL drive data_r_valid_o all-zero.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously clear the pointers, the outstanding count and rsp_err_o to 0; FIFO storage SHALL need no reset.
REQ-029 Reset asserted mid-operation SHALL discard all outstanding IDs; after release, data_gnt_o SHALL follow data_gnt_i immediately.

Structure
REQ-030 DEPTH and the ID and count width derivations SHALL live in the shared XBAR_L2 package, next to the existing crossbar parameters.
REQ-031 The ID FIFO SHALL be one sub-module, xbar_l2_id_fifo (push, pop, full, empty, count, head); routing and error logic SHALL stay in the top.

Verification
REQ-032 The bench SHALL cover: reset, then accepts with IDs 2,0,3 on consecutive cycles, then three r_valid -> data_r_valid_o = 0100, 0001, 1000 in order.
REQ-033 The bench SHALL cover: DEPTH=4, four accepts with no response -> outstanding_o=4, data_gnt_o=0 while data_gnt_i=1, data_req_o=0.
REQ-034 The bench SHALL cover: full, with r_valid and req in the same cycle -> no push that cycle, outstanding_o=3, then the accept succeeds the next cycle.
REQ-035 The bench SHALL cover: outstanding=2 with push ID1 and r_valid in the same cycle -> head channel served, outstanding_o stays 2, ID1 is served after the older entry.
REQ-036 The bench SHALL cover: r_valid with the FIFO empty -> rsp_err_o=1 for one cycle, data_r_valid_o=0, outstanding_o=0.
REQ-037 The bench SHALL cover: rst_n low with 3 outstanding -> outstanding_o=0 asynchronously, and the next r_valid raises rsp_err_o.
